risc_core_hs: RTL and testbench
===============================

Name: risc_core_hs

Overview:
- Parametrised successor to the 8-bit accumulator CPU.
- Same 8-opcode accumulator ISA, but data and address widths are parameters.
- The fixed 8-phase sequencer is replaced by a state machine with a ready/stall memory handshake to external memory, so memory may insert wait states.
- A halted core can be restarted with a `resume` pulse; it sits where the old top-level sat and connects to an external memory block.

Parameters:
- DATA_W, 8, accumulator/memory word width; must be >= ADDR_W+3.
- ADDR_W, 5, address width; PC and operand field width.
- PC_RESET, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  memory address, valid while mem_rd or mem_wr is high.
- mem_rd  out  1  read request; held until mem_rdy.
- mem_wr  out  1  write request; held until mem_rdy.
- mem_wdata  out  DATA_W  store data (= ac) while mem_wr is high.
- mem_rdata  in  DATA_W  read data; sampled on the cycle mem_rdy=1 with mem_rd=1.
- mem_rdy  in  1  memory completes the current request this cycle.
- resume  in  1  leave HALT on the next edge.
- halt  out  1  high while in HALT.
- pc_out  out  ADDR_W  current PC (debug).
- ac_out  out  DATA_W  accumulator (debug).

Behaviour:
- Registers: pc, ac, ir, state.
- Instruction fields: opcode=ir[2:0]; operand=ir[ADDR_W+2:3]; upper ir bits ignored.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Reset (rst=0, async): pc=PC_RESET, ac=0, ir=0, state=START.
  - All outputs are decoded from state, so during reset and in START: mem_rd=mem_wr=0, halt=0, mem_addr=0, mem_wdata=ac=0.
- START: unconditional transition to FETCH on the next edge.
- FETCH: mem_addr=pc, mem_rd=1.
  - mem_rdy=0: stay.
  - mem_rdy=1: ir<=mem_rdata; pc<=pc+1 (modulo 2^ADDR_W, wraps max->0); go EXEC.
- EXEC, by opcode:
  - HLT: go HALT; no memory access.
  - SKZ: if ac==0, pc<=pc+1 (wrapping); go FETCH. Single cycle.
  - JMP: pc<=operand; go FETCH. Single cycle.
  - ADD/AND/XOR/LDA: mem_addr=operand, mem_rd=1; stall until mem_rdy. On rdy, ac<=ac+rdata (mod 2^DATA_W, carry discarded) / ac&rdata / ac^rdata / rdata respectively; go FETCH.
  - STO: mem_addr=operand, mem_wr=1, mem_wdata=ac; stall until mem_rdy; go FETCH. ac unchanged.
- HALT: halt=1; pc points past the HLT. resume=1 -> FETCH next edge. resume outside HALT is ignored.
- Handshake rules:
  - mem_rd and mem_wr are never high together.
  - mem_addr and mem_wdata are stable for the whole request.
  - mem_rdy is ignored when no request is active.
  - Exactly one memory transfer per rdy cycle.
- Timing with mem_rdy tied high: every non-HLT instruction takes 2 cycles (FETCH + EXEC). Each wait cycle adds 1.
- Zero test uses the registered ac, i.e. the value before this instruction.
- Reset mid-stall abandons the request immediately; no state is retained.

Decomposition:
- Package risc_pkg: opcode localparams (OP_HLT..OP_JMP), state encoding (ST_START, ST_FETCH, ST_EXEC, ST_HALT), field-slicing constants.
- One combinational sub-module risc_alu (#DATA_W): inputs ac, rdata, opcode; output result.
- FSM, pc, ac and ir stay in risc_core_hs.

Test Plan:
- Reset then mem_rdy=1, mem[0]=LDA 5 (8'h2D), mem[5]=8'h11 -> fetch addr 0 in cycle 2, read addr 5 in cycle 3, ac_out=8'h11 after cycle 3, pc_out=1.
- ADD with ac=8'hF0 and mem=8'h20 -> ac=8'h10 (wraps); next instruction SKZ does not skip. XOR ac with itself -> ac=0; SKZ then advances pc by 2.
- STO with mem_rdy low for 3 cycles -> mem_wr, mem_addr and mem_wdata held for 4 cycles; exactly one write; next FETCH on the cycle after rdy.
- JMP 31 then sequential fetches -> addresses 31, 0, 1 (pc wrap, ADDR_W=5).
- HLT at addr 3 -> halt=1 and no requests for 10 cycles; resume pulse -> halt=0, fetch from addr 4.
- rst driven low mid-stall during a LDA read -> mem_rd drops asynchronously; after release, fetch from PC_RESET with ac=0. Repeat with DATA_W=16, ADDR_W=8.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the handshaked accumulator core: opcodes,
// sequencer state encoding, and instruction field positions.
package risc_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Opcode sits in the low bits, operand address directly above it.
    localparam int unsigned OPC_W    = 3;
    localparam int unsigned OPND_LSB = 3;

    // Instructions whose execute phase reads a data operand from memory.
    function automatic logic is_rd_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Accumulator datapath: combines the accumulator with the operand read
// from memory according to the current opcode.
module risc_alu
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] result
);

    // Select the new accumulator value; carry out of ADD is dropped.
    always_comb begin
        result = ac;
        case (opcode)
            OP_ADD:  result = ac + rdata;
            OP_AND:  result = ac & rdata;
            OP_XOR:  result = ac ^ rdata;
            OP_LDA:  result = rdata;
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/risc_core_hs.sv
// Parametrised accumulator CPU with a ready/stall memory handshake.
// Every bus output is decoded from the sequencer state, so an async reset
// drops any in-flight request immediately.
module risc_core_hs
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PC_RESET = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    input  logic              resume,
    output logic              halt,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ac_out
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] ir;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] alu_result;

    assign opcode  = ir[OPC_W-1:0];
    assign operand = ir[ADDR_W+OPND_LSB-1:OPND_LSB];

    risc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .ac     (ac),
        .rdata  (mem_rdata),
        .opcode (opcode),
        .result (alu_result)
    );

    // Decode bus request, address and store data from the current state.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
            end
            ST_EXEC: begin
                if (is_rd_op(opcode)) begin
                    mem_rd   = 1'b1;
                    mem_addr = operand;
                end else if (opcode == OP_STO) begin
                    mem_wr    = 1'b1;
                    mem_addr  = operand;
                    mem_wdata = ac;
                end
            end
            default: ;
        endcase
    end

    assign halt   = (state == ST_HALT);
    assign pc_out = pc;
    assign ac_out = ac;

    // Sequencer: each memory phase holds until mem_rdy, then advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_START;
            pc    <= ADDR_W'(PC_RESET);
            ac    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                ST_START: state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_rdy) begin
                        ir    <= mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_HLT: state <= ST_HALT;
                        OP_SKZ: begin
                            if (ac == '0) pc <= pc + ADDR_W'(1);
                            state <= ST_FETCH;
                        end
                        OP_JMP: begin
                            pc    <= operand;
                            state <= ST_FETCH;
                        end
                        OP_STO: begin
                            if (mem_rdy) state <= ST_FETCH;
                        end
                        default: begin
                            if (mem_rdy) begin
                                ac    <= alu_result;
                                state <= ST_FETCH;
                            end
                        end
                    endcase
                end
                ST_HALT: begin
                    if (resume) state <= ST_FETCH;
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_core_hs.sv
// Bench for risc_core_hs: a memory model with programmable wait states
// and a scoreboard of expected bus transfers, plus a wide-configuration
// instance exercised for reset during a stalled read.
module tb_risc_core_hs;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- narrow instance (DATA_W=8, ADDR_W=5) ----------------
    logic       rst, resume, mem_rd, mem_wr, mem_rdy, halt;
    logic [4:0] mem_addr, pc_out;
    logic [7:0] mem_wdata, mem_rdata, ac_out;
    logic [7:0] mem [32];

    assign mem_rdata = mem[mem_addr];

    risc_core_hs #(
        .DATA_W   (8),
        .ADDR_W   (5),
        .PC_RESET (0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .resume    (resume),
        .halt      (halt),
        .pc_out    (pc_out),
        .ac_out    (ac_out)
    );

    // ---------------- wide instance (DATA_W=16, ADDR_W=8) ----------------
    logic        w_rst, w_resume, w_rd, w_wr, w_rdy, w_halt, w_blk;
    logic [7:0]  w_addr, w_pc;
    logic [15:0] w_wdata, w_rdata, w_ac;
    logic [15:0] wmem [256];

    assign w_rdata = wmem[w_addr];
    assign w_rdy   = !(w_blk && w_rd && (w_addr == 8'd202));

    risc_core_hs #(
        .DATA_W   (16),
        .ADDR_W   (8),
        .PC_RESET (0)
    ) u_dut_w (
        .clk       (clk),
        .rst       (w_rst),
        .mem_addr  (w_addr),
        .mem_rd    (w_rd),
        .mem_wr    (w_wr),
        .mem_wdata (w_wdata),
        .mem_rdata (w_rdata),
        .mem_rdy   (w_rdy),
        .resume    (w_resume),
        .halt      (w_halt),
        .pc_out    (w_pc),
        .ac_out    (w_ac)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] ac;
    } txn_t;

    txn_t sb_q[$];

    task automatic exp_fetch(input logic [4:0] a, input logic [7:0] acv);
        sb_q.push_back('{1'b0, a, 8'h00, acv});
    endtask

    task automatic exp_read(input logic [4:0] a, input logic [7:0] acv);
        sb_q.push_back('{1'b0, a, 8'h00, acv});
    endtask

    task automatic exp_write(input logic [4:0] a, input logic [7:0] d, input logic [7:0] acv);
        sb_q.push_back('{1'b1, a, d, acv});
    endtask

    // ---------------- memory model / bus monitor ----------------
    int         wr_wait   = 0;
    bit         blk5      = 1'b0;
    int         wait_left = 0;
    int         held      = 0;
    bit         prev_req  = 1'b0;
    bit         prev_done = 1'b0;
    bit         after_wr  = 1'b0;
    bit         mon_req;
    logic [4:0] prev_addr;
    logic [7:0] prev_wdata;
    txn_t       got_t;

    initial mem_rdy = 1'b0;

    // Drive mem_rdy for the coming edge and score every completed transfer.
    always @(negedge clk) begin
        mon_req = mem_rd | mem_wr;
        if (after_wr) begin
            after_wr = 1'b0;
            check("fetch_after_sto", {31'd0, mem_rd}, 32'd1);
        end
        if (mon_req) begin
            check("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
            if (prev_req && !prev_done) begin
                check("addr_stable", {27'd0, mem_addr}, {27'd0, prev_addr});
                if (mem_wr) check("wdata_stable", {24'd0, mem_wdata}, {24'd0, prev_wdata});
                held++;
            end else begin
                held      = 1;
                wait_left = mem_wr ? wr_wait : 0;
            end
            if (wait_left > 0) begin
                mem_rdy = 1'b0;
                wait_left--;
            end else begin
                mem_rdy = !(blk5 && mem_rd && (mem_addr == 5'd5));
            end
            if (mem_rdy) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", sb_q.size(), 32'd1);
                end else begin
                    got_t = sb_q.pop_front();
                    check("sb_kind", {31'd0, mem_wr}, {31'd0, got_t.wr});
                    check("sb_addr", {27'd0, mem_addr}, {27'd0, got_t.addr});
                    check("sb_ac", {24'd0, ac_out}, {24'd0, got_t.ac});
                    if (got_t.wr) begin
                        check("sb_wdata", {24'd0, mem_wdata}, {24'd0, got_t.data});
                        check("wr_hold_cycles", held, wr_wait + 1);
                        after_wr = 1'b1;
                    end
                end
                if (mem_wr) mem[mem_addr] = mem_wdata;
            end
        end else begin
            mem_rdy = 1'b1 & ($urandom_range(0, 1) != 0);
        end
        prev_req   = mon_req;
        prev_done  = mon_req && mem_rdy;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    // ---------------- helpers ----------------
    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    task automatic run_until_halt(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!halt && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, halt}, 32'd1);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b0;
        resume   = 1'b0;
        w_rst    = 1'b0;
        w_resume = 1'b0;
        w_blk    = 1'b0;
        clear_mem();
        foreach (wmem[i]) wmem[i] = 16'h0000;

        repeat (2) @(negedge clk);
        check("rst_mem_rd",    {31'd0, mem_rd}, 32'd0);
        check("rst_mem_wr",    {31'd0, mem_wr}, 32'd0);
        check("rst_halt",      {31'd0, halt}, 32'd0);
        check("rst_mem_addr",  {27'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_pc",        {27'd0, pc_out}, 32'd0);
        check("rst_ac",        {24'd0, ac_out}, 32'd0);
        check("w_rst_wdata",   {16'd0, w_wdata}, 32'd0);

        // Phase A: LDA timing, ADD wrap, SKZ both ways, stalled STO.
        mem[0]  = 8'h2D; mem[1]  = 8'h47; mem[5]  = 8'h11;
        mem[8]  = 8'hA5; mem[9]  = 8'hAA; mem[10] = 8'h01;
        mem[11] = 8'hB4; mem[12] = 8'h01; mem[13] = 8'h00;
        mem[14] = 8'hC5; mem[15] = 8'hBE; mem[16] = 8'h00;
        mem[20] = 8'hF0; mem[21] = 8'h20; mem[22] = 8'h10;
        mem[24] = 8'h5A;
        wr_wait = 3;
        exp_fetch(5'd0, 8'h00);  exp_read(5'd5, 8'h00);
        exp_fetch(5'd1, 8'h11);  exp_fetch(5'd8, 8'h11);
        exp_read(5'd20, 8'h11);  exp_fetch(5'd9, 8'hF0);
        exp_read(5'd21, 8'hF0);  exp_fetch(5'd10, 8'h10);
        exp_fetch(5'd11, 8'h10); exp_read(5'd22, 8'h10);
        exp_fetch(5'd12, 8'h00); exp_fetch(5'd14, 8'h00);
        exp_read(5'd24, 8'h00);  exp_fetch(5'd15, 8'h5A);
        exp_write(5'd23, 8'h5A, 8'h5A);
        exp_fetch(5'd16, 8'h5A);
        release_rst();
        @(negedge clk);
        check("c1_start_idle", {31'd0, mem_rd | mem_wr}, 32'd0);
        @(negedge clk);
        check("c2_fetch_rd",   {31'd0, mem_rd}, 32'd1);
        check("c2_fetch_addr", {27'd0, mem_addr}, 32'd0);
        @(negedge clk);
        check("c3_read_rd",    {31'd0, mem_rd}, 32'd1);
        check("c3_read_addr",  {27'd0, mem_addr}, 32'd5);
        @(negedge clk);
        check("c4_ac",         {24'd0, ac_out}, 32'h11);
        check("c4_pc",         {27'd0, pc_out}, 32'd1);
        run_until_halt(200, "a_halt");
        check("a_pc",    {27'd0, pc_out}, 32'd17);
        check("a_ac",    {24'd0, ac_out}, 32'h5A);
        check("a_drain", sb_q.size(), 32'd0);

        // Phase B: jump to 31 with pc wrap, HLT at 3, resume, ignored early resume.
        #2 rst = 1'b0;
        wr_wait = 0;
        clear_mem();
        mem[0]  = 8'h01; mem[1]  = 8'h1F; mem[2]  = 8'hEF;
        mem[3]  = 8'h00; mem[4]  = 8'h5D; mem[5]  = 8'h00;
        mem[10] = 8'h33; mem[11] = 8'h77;
        mem[29] = 8'h55; mem[30] = 8'hFF; mem[31] = 8'h01;
        exp_fetch(5'd0, 8'h00);  exp_fetch(5'd2, 8'h00);
        exp_fetch(5'd29, 8'h00); exp_read(5'd10, 8'h00);
        exp_fetch(5'd30, 8'h33); exp_fetch(5'd31, 8'h33);
        exp_fetch(5'd0, 8'h33);  exp_fetch(5'd1, 8'h33);
        exp_fetch(5'd3, 8'h33);
        exp_fetch(5'd4, 8'h33);  exp_read(5'd11, 8'h33);
        exp_fetch(5'd5, 8'h77);
        release_rst();
        resume = 1'b1;
        repeat (3) @(negedge clk);
        resume = 1'b0;
        run_until_halt(100, "b_halt1");
        check("b_halt_pc", {27'd0, pc_out}, 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b_halt_held", {31'd0, halt}, 32'd1);
            check("b_halt_idle", {31'd0, mem_rd | mem_wr}, 32'd0);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("b_resume_halt", {31'd0, halt}, 32'd0);
        check("b_resume_rd",   {31'd0, mem_rd}, 32'd1);
        check("b_resume_addr", {27'd0, mem_addr}, 32'd4);
        run_until_halt(100, "b_halt2");
        check("b_pc",    {27'd0, pc_out}, 32'd6);
        check("b_ac",    {24'd0, ac_out}, 32'h77);
        check("b_drain", sb_q.size(), 32'd0);

        // Phase C: reset while the LDA operand read is stalled.
        #2 rst = 1'b0;
        clear_mem();
        mem[0] = 8'h2D; mem[1] = 8'h00; mem[5] = 8'h11;
        blk5 = 1'b1;
        exp_fetch(5'd0, 8'h00);
        release_rst();
        repeat (3) @(negedge clk);
        check("c_stall_rd",   {31'd0, mem_rd}, 32'd1);
        check("c_stall_addr", {27'd0, mem_addr}, 32'd5);
        @(negedge clk);
        check("c_stall_hold", {31'd0, mem_rd}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("c_abort_rd",   {31'd0, mem_rd}, 32'd0);
        check("c_abort_addr", {27'd0, mem_addr}, 32'd0);
        check("c_abort_pc",   {27'd0, pc_out}, 32'd0);
        check("c_abort_ac",   {24'd0, ac_out}, 32'd0);
        blk5 = 1'b0;
        exp_fetch(5'd0, 8'h00); exp_read(5'd5, 8'h00); exp_fetch(5'd1, 8'h11);
        @(negedge clk);
        release_rst();
        run_until_halt(100, "c_halt");
        check("c_ac",    {24'd0, ac_out}, 32'h11);
        check("c_pc",    {27'd0, pc_out}, 32'd2);
        check("c_drain", sb_q.size(), 32'd0);

        // Phase D: wide configuration, ADD wrap then reset mid-stall.
        wmem[0]   = 16'h0645; wmem[1]   = 16'h064A;
        wmem[2]   = 16'h0655; wmem[3]   = 16'h0000;
        wmem[200] = 16'hFFF0; wmem[201] = 16'h0025; wmem[202] = 16'hABCD;
        w_blk = 1'b1;
        @(posedge clk);
        #2 w_rst = 1'b1;
        begin
            int n;
            n = 0;
            while (!(w_rd && w_addr == 8'd202) && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("w_stall_seen", {31'd0, w_rd && (w_addr == 8'd202)}, 32'd1);
        check("w_add_wrap",   {16'd0, w_ac}, 32'h0015);
        check("w_stall_pc",   {24'd0, w_pc}, 32'd3);
        check("w_no_store",   {31'd0, w_wr}, 32'd0);
        @(negedge clk);
        #2 w_rst = 1'b0;
        #1;
        check("w_abort_rd", {31'd0, w_rd}, 32'd0);
        check("w_abort_pc", {24'd0, w_pc}, 32'd0);
        check("w_abort_ac", {16'd0, w_ac}, 32'd0);
        w_blk = 1'b0;
        @(posedge clk);
        #2 w_rst = 1'b1;
        begin
            int n;
            n = 0;
            while (!w_halt && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("w_halt", {31'd0, w_halt}, 32'd1);
        check("w_ac",   {16'd0, w_ac}, 32'hABCD);
        check("w_pc",   {24'd0, w_pc}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
